gate_identifier: RTL and testbench
==================================

# gate_identifier

Sequential truth-table decoder for two-input gates: drives or observes `(a, b)` samples and the gate's response `y`, accumulates a 4-entry truth table over a valid/ready stream, and reports which primitive (NOT, AND, NAND, OR, NOR, XOR, XNOR) produced it. It is the inverse of the gate bank. Given gate behaviour, it recovers gate identity. It sits beside the gate bank as a self-check / classification block driven by a bench or a control FSM.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum cycles spent collecting before abort; legal range >= 4.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a new identification; honoured only in IDLE or REPORT.
- `sample_valid`  in  1  `a`, `b`, `y` hold a valid sample.
- `a`  in  1  gate input a of the sample.
- `b`  in  1  gate input b of the sample.
- `y`  in  1  observed gate output for `(a, b)`.
- `sample_ready`  out  1  high only in COLLECT.
- `busy`  out  1  high in COLLECT.
- `done`  out  1  single-cycle pulse on entry to REPORT.
- `gate_code`  out  3  0 UNKNOWN, 1 NOT, 2 AND, 3 NAND, 4 OR, 5 NOR, 6 XOR, 7 XNOR; held until the next `start`.
- `conflict`  out  1  same `(a, b)` seen twice with differing `y`; held with `gate_code`.
- `timeout`  out  1  table incomplete after `TIMEOUT` cycles; held with `gate_code`.

## Operation
- Reset: state IDLE. `tt`, `seen`, and the counter are cleared. All outputs are 0.
- Truth table `tt[3:0]`: bit `{a,b}` holds `y`. `seen[3:0]` marks the entries that have been written.
- Codes:
  - NOT (y = ~a): `tt` = 0011
  - AND: 1000
  - NAND: 0111
  - OR: 1110
  - NOR: 0001
  - XOR: 0110
  - XNOR: 1001
  - Any other value, including constants and buffers: UNKNOWN.
- IDLE:
  - On `start`, clear `tt`, `seen`, the counter, `gate_code`, `conflict` and `timeout`, then go to COLLECT.
- COLLECT:
  - A handshake is `sample_valid && sample_ready`.
  - On a handshake to a new index, write `tt` and `seen`.
  - On a duplicate index with equal `y`, accept the sample with no effect.
  - On a duplicate index with differing `y`, set `conflict`, set `gate_code` = 0, and go to REPORT.
  - When `seen` becomes 1111 (including the completing sample), decode `tt` into `gate_code` and go to REPORT.
  - The counter increments every COLLECT cycle. At count `TIMEOUT-1` with no completing handshake, set `timeout`, set `gate_code` = 0, and go to REPORT.
  - `start` is ignored in COLLECT.
- REPORT:
  - `done` is high for exactly the first cycle.
  - The state stays in REPORT (results held) until `start`, which behaves as in IDLE.
  - `start` during the `done` cycle is honoured.
- Priority in a single cycle: conflict > completion > timeout. A completing sample on the timeout cycle reports the gate, with `timeout` = 0.

## Timing
- `start` sampled at edge 0 gives COLLECT and `sample_ready` = 1 from cycle 1.
- The final handshake at edge k gives `done` = 1 and valid `gate_code`/flags during cycle k+1.
- Minimum run with four back-to-back samples: `done` in cycle 5 after `start`.
- Timeout: `done` in cycle `TIMEOUT`+1 after `start`.
- Counter width is `$clog2(TIMEOUT+1)`. It never wraps.
- `rst_n` asserted mid-COLLECT returns immediately to the reset state. No `done` is issued.
- All outputs are registered. There are no combinational paths from inputs to outputs, except that `sample_ready` is decoded from state only.

## Structure
- Package `gate_id_pkg` holds:
  - the state encoding (IDLE, COLLECT, REPORT);
  - the `gate_code` constants;
  - the seven truth-table constants.
- Sub-module `gate_tt_decode` is purely combinational: 4-bit `tt` in, 3-bit code out. It is instantiated once, and the FSM registers its result.

## Test plan
- AND samples (00→0, 01→0, 10→0, 11→1) back-to-back after `start` -> `done` in cycle 5, `gate_code` = 2, `conflict` = `timeout` = 0.
- XNOR samples in the order 11, 00, 01, 10 with `sample_valid` gaps, plus a repeat of 00→1 -> `gate_code` = 7, no conflict.
- Samples 10→1, 10→0 -> `conflict` = 1, `gate_code` = 0, `done` the cycle after the second handshake.
- Only three distinct indices supplied, `TIMEOUT` = 8 -> `timeout` = 1, `gate_code` = 0, `done` in cycle 9.
- Constant-1 table (1111) -> `gate_code` = 0, both flags 0. Then `start` in the `done` cycle with NOT samples (00→1, 01→1, 10→0, 11→0) -> `gate_code` = 1.
- `rst_n` low after two samples -> all outputs 0 and state IDLE. A subsequent full OR run reports 4.

Source files
------------

// File: rtl/gate_id_pkg.sv
// Shared encodings for the gate identifier: FSM states, gate codes and reference truth tables.
// Truth-table bit {a,b} holds y, so tt[3] is the y observed for a=1,b=1.
package gate_id_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    localparam logic [2:0] GC_UNKNOWN = 3'd0;
    localparam logic [2:0] GC_NOT     = 3'd1;
    localparam logic [2:0] GC_AND     = 3'd2;
    localparam logic [2:0] GC_NAND    = 3'd3;
    localparam logic [2:0] GC_OR      = 3'd4;
    localparam logic [2:0] GC_NOR     = 3'd5;
    localparam logic [2:0] GC_XOR     = 3'd6;
    localparam logic [2:0] GC_XNOR    = 3'd7;

    localparam logic [3:0] TT_NOT  = 4'b0011;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_tt_decode.sv
// Maps a complete 4-entry truth table to a gate code; purely combinational, no flow control.
// Constants, buffers and any other unlisted table decode to UNKNOWN.
module gate_tt_decode
    import gate_id_pkg::*;
(
    input  logic [3:0] i_tt,
    output logic [2:0] o_code
);

    always_comb begin
        o_code = GC_UNKNOWN;
        case (i_tt)
            TT_NOT:  o_code = GC_NOT;
            TT_AND:  o_code = GC_AND;
            TT_NAND: o_code = GC_NAND;
            TT_OR:   o_code = GC_OR;
            TT_NOR:  o_code = GC_NOR;
            TT_XOR:  o_code = GC_XOR;
            TT_XNOR: o_code = GC_XNOR;
            default: o_code = GC_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/gate_identifier.sv
// Collects (a,b,y) samples into a truth table and reports the gate; result one cycle after the final handshake.
// Backpressure: sample_ready is high only while collecting; results are held in REPORT until the next start.
module gate_identifier
    import gate_id_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sample_valid,
    input  logic       a,
    input  logic       b,
    input  logic       y,
    output logic       sample_ready,
    output logic       busy,
    output logic       done,
    output logic [2:0] gate_code,
    output logic       conflict,
    output logic       timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    logic [3:0]    r_tt;
    logic [3:0]    r_seen;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_code;
    logic          r_conflict;
    logic          r_timeout;
    logic          r_done;
    logic          r_busy;

    logic [1:0]    w_idx;
    logic          w_hs;
    logic [3:0]    w_tt_nxt;
    logic [3:0]    w_seen_nxt;
    logic          w_conflict;
    logic          w_complete;
    logic [2:0]    w_code;

    assign w_idx      = {a, b};
    assign w_hs       = sample_valid && (r_state == ST_COLLECT);
    assign w_seen_nxt = r_seen | (4'b0001 << w_idx);
    assign w_conflict = w_hs && r_seen[w_idx] && (r_tt[w_idx] != y);
    assign w_complete = w_hs && (w_seen_nxt == 4'b1111);

    always_comb begin
        w_tt_nxt        = r_tt;
        w_tt_nxt[w_idx] = y;
    end

    // Decode the table including the current sample so completion reports in the next cycle.
    gate_tt_decode u_decode (
        .i_tt   (w_tt_nxt),
        .o_code (w_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tt       <= 4'b0000;
            r_seen     <= 4'b0000;
            r_cnt      <= '0;
            r_code     <= GC_UNKNOWN;
            r_conflict <= 1'b0;
            r_timeout  <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_REPORT: begin
                    if (start) begin
                        r_state    <= ST_COLLECT;
                        r_tt       <= 4'b0000;
                        r_seen     <= 4'b0000;
                        r_cnt      <= '0;
                        r_code     <= GC_UNKNOWN;
                        r_conflict <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    // Leaving at CNT_LAST at the latest keeps the counter from wrapping.
                    r_cnt <= r_cnt + CW'(1);
                    if (w_conflict) begin
                        r_conflict <= 1'b1;
                        r_code     <= GC_UNKNOWN;
                        r_state    <= ST_REPORT;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                    end else if (w_complete) begin
                        r_tt    <= w_tt_nxt;
                        r_seen  <= w_seen_nxt;
                        r_code  <= w_code;
                        r_state <= ST_REPORT;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_timeout <= 1'b1;
                        r_code    <= GC_UNKNOWN;
                        r_state   <= ST_REPORT;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end else if (w_hs) begin
                        r_tt   <= w_tt_nxt;
                        r_seen <= w_seen_nxt;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sample_ready = (r_state == ST_COLLECT);
    assign busy         = r_busy;
    assign done         = r_done;
    assign gate_code    = r_code;
    assign conflict     = r_conflict;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_gate_identifier.sv
// Directed bench for gate_identifier with TIMEOUT=8; cycle n means n rising edges after the start edge.
module tb_gate_identifier;
    import gate_id_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sample_valid;
    logic       a;
    logic       b;
    logic       y;
    logic       sample_ready;
    logic       busy;
    logic       done;
    logic [2:0] gate_code;
    logic       conflict;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    gate_identifier #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sample_valid (sample_valid),
        .a            (a),
        .b            (b),
        .y            (y),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .gate_code    (gate_code),
        .conflict     (conflict),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic ia, input logic ib, input logic iy);
        sample_valid = 1'b1;
        a = ia;
        b = ib;
        y = iy;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_tests++;
        if ({sample_ready, busy, done, gate_code, conflict, timeout} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=00000000", {sample_ready, busy, done, gate_code, conflict, timeout});
        end
        tick();
        rst_n = 1'b1;
        idle(2);
        n_tests++;
        if (sample_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset ready=%b busy=%b want 0 0", sample_ready, busy);
        end
    endtask

    task automatic test_and_back_to_back();
        do_start();
        n_tests++;
        if (sample_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL and_collect_c1 ready=%b busy=%b want 1 1", sample_ready, busy);
        end
        send(0, 0, 0);
        send(0, 1, 0);
        send(1, 0, 0);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL and_early_done got=%b want=0 at cycle 4", done);
        end
        send(1, 1, 1);
        n_tests++;
        if ({done, gate_code, conflict, timeout, busy, sample_ready} !== {1'b1, GC_AND, 4'b0000}) begin
            n_fail++;
            $display("FAIL and_report done=%b code=%0d cf=%b to=%b busy=%b rdy=%b want done=1 code=2 rest 0",
                     done, gate_code, conflict, timeout, busy, sample_ready);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || gate_code !== GC_AND) begin
            n_fail++;
            $display("FAIL and_hold done=%b code=%0d want done=0 code=2", done, gate_code);
        end
    endtask

    task automatic test_xnor_gaps();
        do_start();
        send(1, 1, 1);
        start = 1'b1;
        idle(1);
        start = 1'b0;
        send(0, 0, 1);
        send(0, 0, 1);
        idle(1);
        send(0, 1, 0);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL xnor_midrun done=%b busy=%b want 0 1", done, busy);
        end
        send(1, 0, 0);
        n_tests++;
        if ({done, gate_code, conflict, timeout} !== {1'b1, GC_XNOR, 2'b00}) begin
            n_fail++;
            $display("FAIL xnor_report done=%b code=%0d cf=%b to=%b want 1 7 0 0", done, gate_code, conflict, timeout);
        end
    endtask

    task automatic test_conflict();
        do_start();
        send(1, 0, 1);
        send(1, 0, 0);
        n_tests++;
        if ({done, gate_code, conflict, timeout} !== {1'b1, GC_UNKNOWN, 2'b10}) begin
            n_fail++;
            $display("FAIL conflict_report done=%b code=%0d cf=%b to=%b want 1 0 1 0", done, gate_code, conflict, timeout);
        end
        idle(3);
        n_tests++;
        if (conflict !== 1'b1 || done !== 1'b0 || sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_hold cf=%b done=%b rdy=%b want 1 0 0", conflict, done, sample_ready);
        end
    endtask

    task automatic test_timeout();
        do_start();
        send(0, 0, 1);
        send(0, 1, 1);
        send(1, 1, 0);
        idle(4);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_c8 done=%b busy=%b want 0 1", done, busy);
        end
        idle(1);
        n_tests++;
        if ({done, gate_code, conflict, timeout, busy} !== {1'b1, GC_UNKNOWN, 3'b010}) begin
            n_fail++;
            $display("FAIL timeout_report done=%b code=%0d cf=%b to=%b busy=%b want 1 0 0 1 0",
                     done, gate_code, conflict, timeout, busy);
        end
    endtask

    task automatic test_complete_on_timeout_cycle();
        do_start();
        send(0, 0, 0);
        idle(3);
        send(0, 1, 1);
        send(1, 0, 1);
        idle(1);
        send(1, 1, 0);
        n_tests++;
        if ({done, gate_code, conflict, timeout} !== {1'b1, GC_XOR, 2'b00}) begin
            n_fail++;
            $display("FAIL late_complete done=%b code=%0d cf=%b to=%b want 1 6 0 0", done, gate_code, conflict, timeout);
        end
    endtask

    task automatic test_const_then_not();
        do_start();
        send(0, 0, 1);
        send(0, 1, 1);
        send(1, 0, 1);
        send(1, 1, 1);
        n_tests++;
        if ({done, gate_code, conflict, timeout} !== {1'b1, GC_UNKNOWN, 2'b00}) begin
            n_fail++;
            $display("FAIL const1_report done=%b code=%0d cf=%b to=%b want 1 0 0 0", done, gate_code, conflict, timeout);
        end
        do_start();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1 || sample_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_in_done done=%b busy=%b rdy=%b want 0 1 1", done, busy, sample_ready);
        end
        send(0, 0, 1);
        send(0, 1, 1);
        send(1, 0, 0);
        send(1, 1, 0);
        n_tests++;
        if ({done, gate_code, conflict, timeout} !== {1'b1, GC_NOT, 2'b00}) begin
            n_fail++;
            $display("FAIL not_report done=%b code=%0d cf=%b to=%b want 1 1 0 0", done, gate_code, conflict, timeout);
        end
    endtask

    task automatic test_reset_midrun();
        do_start();
        send(0, 0, 0);
        send(0, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sample_ready, busy, done, gate_code, conflict, timeout} !== 8'h00 || dut.r_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL midrun_reset outs=%b state=%0d want 00000000 state 0",
                     {sample_ready, busy, done, gate_code, conflict, timeout}, dut.r_state);
        end
        tick();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset_done got=%b want=0", done);
        end
        #2;
        rst_n = 1'b1;
        tick();
        do_start();
        send(0, 0, 0);
        send(0, 1, 1);
        send(1, 0, 1);
        send(1, 1, 1);
        n_tests++;
        if ({done, gate_code, conflict, timeout} !== {1'b1, GC_OR, 2'b00}) begin
            n_fail++;
            $display("FAIL or_after_reset done=%b code=%0d cf=%b to=%b want 1 4 0 0", done, gate_code, conflict, timeout);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        sample_valid = 1'b0;
        a            = 1'b0;
        b            = 1'b0;
        y            = 1'b0;
        test_reset();
        test_and_back_to_back();
        test_xnor_gaps();
        test_conflict();
        test_timeout();
        test_complete_on_timeout_cycle();
        test_const_then_not();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
